// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter that lets four requesters share one FIFO write
// port. A requester that wins arbitration owns the port for a burst of up
// to BURST beats. The burst ends early when the owner marks a beat with
// 'last' or drops its request. Every burst is followed by exactly one idle
// cycle, and that cycle is where the next winner is chosen.
//
// Parameters
//   WIDTH       data width of each requester lane and of the FIFO write port
//   BURST       maximum beats per grant (1..16)
// Ports
//   clk         rising-edge clock
//   res         synchronous reset, active low
//   req[3:0]    per-requester write request
//   last[3:0]   per-requester end-of-burst marker, qualified by req
//   req_data    requester i data at [i*WIDTH +: WIDTH]
//   full        downstream FIFO full flag
//   fifo_wr_en  FIFO write enable
//   fifo_wdata  FIFO write data (lane of the owner while busy, else 0)
//   gnt[3:0]    one-hot strobe: the owner's beat is written this cycle
//   busy        high while a requester owns the port
//   owner[1:0]  current or most recent grant holder
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               res,
    input  logic [3:0]         req,
    input  logic [3:0]         last,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic               full,
    output logic               fifo_wr_en,
    output logic [WIDTH-1:0]   fifo_wdata,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic [1:0]         owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t           state;
    logic [1:0]       owner_q;
    logic [1:0]       last_owner;
    logic [3:0]       beat_cnt;
    logic [1:0]       next_pick;
    logic [1:0]       cand;
    logic             accept;
    logic [WIDTH-1:0] lane [4];

    // Split the packed request data into lanes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Rotating priority: scan last_owner+4 down to last_owner+1. Later hits
    // overwrite earlier ones, so the requester closest after last_owner wins.
    // An offset of 4 wraps to last_owner itself, so it has the lowest priority.
    always_comb begin
        next_pick = last_owner;
        cand      = last_owner;
        for (int k = 4; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                next_pick = cand;
            end
        end
    end

    // All outputs are gated by res. This keeps them quiet in the reset cycle
    // itself, even when the registers still hold a burst in progress.
    always_comb begin
        busy       = res && (state == GRANT);
        accept     = busy && req[owner_q] && !full;
        fifo_wr_en = accept;
        gnt        = accept ? (4'b0001 << owner_q) : 4'b0000;
        fifo_wdata = busy ? lane[owner_q] : '0;
        owner      = res ? owner_q : 2'd0;
    end

    // Two-state control FSM.
    // While full is high the burst stalls in place, and the last marker is
    // not consumed until its beat is actually written.
    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= IDLE;
            owner_q    <= 2'd0;
            last_owner <= 2'd3;
            beat_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner_q    <= next_pick;
                        last_owner <= next_pick;
                        beat_cnt   <= 4'd0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner_q]) begin
                        state <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (last[owner_q] || (beat_cnt == LAST_BEAT)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001 Parameter WIDTH, default 8: data width of each requester lane and of the FIFO write port.
- REQ-002 Parameter BURST, default 4: maximum beats per grant; legal range 1..16.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 res  input  1  reset; synchronous and active-low (res==0 at a clk edge resets the block).
- REQ-005 req  input  4  per-requester write request; bit i belongs to requester i.
- REQ-006 last  input  4  per-requester end-of-burst marker; qualified by req[i].
- REQ-007 req_data  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- REQ-008 full  input  1  downstream FIFO full flag.
- REQ-009 fifo_wr_en  output  1  FIFO write enable.
- REQ-010 fifo_wdata  output  WIDTH  FIFO write data.
- REQ-011 gnt  output  4  one-hot beat-accepted strobe; gnt[i]=1 means requester i's current beat is written this cycle.
- REQ-012 busy  output  1  high while in GRANT.
- REQ-013 owner  output  2  index of the current or most recent grant holder.

Function
- REQ-014 The block SHALL implement a two-state FSM, IDLE and GRANT, with registered owner, last_owner (2 bit) and beat_cnt (4 bit).
- REQ-015 IDLE, req!=0: the block SHALL select the first i with req[i]==1 in the order last_owner+1, +2, +3, +4 (mod 4), load owner=i and last_owner=i, clear beat_cnt, and enter GRANT next cycle.
- REQ-016 IDLE, req==0: the block SHALL stay in IDLE, with fifo_wr_en=0 and gnt=0.
- REQ-017 In GRANT, accept = req[owner] & ~full (combinational); fifo_wr_en=accept, gnt=accept ? onehot(owner) : 0, fifo_wdata=req_data lane owner.
- REQ-018 fifo_wdata SHALL equal lane owner whenever busy=1 and SHALL be 0 in IDLE.
- REQ-019 Each accepted beat SHALL increment beat_cnt; with full=1 there SHALL be no write, beat_cnt SHALL hold and ownership SHALL hold (no timeout).
- REQ-020 GRANT SHALL return to IDLE after an accepted beat with last[owner]=1, or after an accepted beat with beat_cnt==BURST-1, whichever occurs first.
- REQ-021 GRANT SHALL return to IDLE without a write in any cycle where req[owner]==0 (requester abandons the burst).
- REQ-022 last[owner]=1 coinciding with full=1 SHALL NOT end the burst; the beat and its last marker are retried.
- REQ-023 Every GRANT->IDLE transition SHALL cost exactly one IDLE cycle (one bubble) before the next grant.
- REQ-024 Requests from non-owners SHALL be ignored during GRANT: no gnt, and no effect on state.
- REQ-025 Arbitration SHALL be starvation-free: a continuously requesting requester is granted within 3 other grants.
- REQ-026 fifo_wr_en SHALL never be 1 while full==1, so the FIFO overflow flag is never set by this block.

Reset
- REQ-027 While res==0 at a clk edge, the block SHALL set state=IDLE, owner=0, last_owner=3 (so requester 0 has first priority) and beat_cnt=0.
- REQ-028 During and after reset, outputs SHALL be fifo_wr_en=0, gnt=0, busy=0, owner=0 and fifo_wdata=0.
- REQ-029 Reset asserted mid-burst SHALL abort the burst with no further write; after release, arbitration restarts from requester 0 priority.

Verification
- REQ-030 Reset release, req=4'b1111 held, last=0, full=0, BURST=4 -> grants in the order 0,1,2,3,0; each grant gives 4 consecutive gnt pulses then 1 bubble.
- REQ-031 req=4'b0100, last[2] asserted on the 2nd beat -> exactly 2 writes with data lane 2, then busy falls; owner=2 persists.
- REQ-032 Owner 1 mid-burst, full held high 5 cycles -> fifo_wr_en=0 and beat_cnt frozen for those cycles; remaining beats written after full falls, 4 beats total.
- REQ-033 Owner 3 deasserts req after 1 beat -> return to IDLE, 1 write only; next grant goes to the lowest set bit starting from 0.
- REQ-034 res=0 during the 3rd beat of owner 2 -> no write in the reset cycle; after release with req=4'b1100, the first grant goes to 2.
- REQ-035 Scoreboard over random traffic -> FIFO content order equals accepted gnt order with matching lane data; zero fifo_wr_en while full=1.
